// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and opcode helpers
// for the ALU issue controller and the ALU itself.
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD      = 4'd1;
    localparam logic [OP_W-1:0] OP_SUB      = 4'd2;
    localparam logic [OP_W-1:0] OP_MUL      = 4'd3;
    localparam logic [OP_W-1:0] OP_MOD      = 4'd4;
    localparam logic [OP_W-1:0] OP_PASSATOC = 4'd5;
    localparam logic [OP_W-1:0] OP_PASSBTOC = 4'd6;
    localparam logic [OP_W-1:0] OP_INCAC    = 4'd7;
    localparam logic [OP_W-1:0] OP_DECAC    = 4'd8;
    localparam logic [OP_W-1:0] OP_RESET    = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_DONE
    } state_e;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_RESET);
    endfunction

endpackage

// File: rtl/issue_latency_counter.sv
// Counts ALU evaluation cycles; tc flags that the programmed
// latency has been reached.
module issue_latency_counter #(
    parameter int LATENCY = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic count_en,
    output logic tc
);

    logic [3:0] cnt;

    assign tc = (cnt == 4'(LATENCY));

    // Holding at terminal count keeps the counter from wrapping at 15.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= 4'd1;
        end else if (count_en && !tc) begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one decoder operation at a time to the ALU, waits its
// fixed latency, then captures the result into the accumulator.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [OP_W-1:0]   op_code,
    input  logic [DATA_W-1:0] op_operand,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_control,
    output logic              alu_enable,
    input  logic [DATA_W-1:0] alu_c,
    output logic [DATA_W-1:0] ac_out,
    output logic              z_out,
    output logic              done,
    output logic              err
);

    state_e            state;
    state_e            state_nxt;
    logic [DATA_W-1:0] ac;
    logic              illegal_q;
    logic              legal;
    logic              tc;

    logic issue_go;
    logic mark_illegal;
    logic cnt_en;
    logic en_drop;
    logic capture;
    logic finish;

    assign legal    = is_legal_op(op_code);
    assign op_ready = (state == S_IDLE) && !reset;
    assign ac_out   = ac;

    issue_latency_counter #(
        .LATENCY (LATENCY)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (issue_go),
        .count_en (cnt_en),
        .tc       (tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Illegal ops pass through CAPTURE without touching AC, so the
    // done/err pulse lands one cycle after acceptance plus one.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (op_valid) begin
                    state_nxt = legal ? S_ISSUE : S_CAPTURE;
                end
            end
            S_ISSUE: begin
                if (tc) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        issue_go     = 1'b0;
        mark_illegal = 1'b0;
        cnt_en       = 1'b0;
        en_drop      = 1'b0;
        capture      = 1'b0;
        finish       = 1'b0;
        unique case (1'b1)
            (state == S_IDLE): begin
                issue_go     = op_valid && legal;
                mark_illegal = op_valid && !legal;
            end
            (state == S_ISSUE): begin
                cnt_en  = 1'b1;
                en_drop = tc;
            end
            (state == S_CAPTURE): begin
                capture = !illegal_q;
                finish  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            alu_enable  <= 1'b0;
            ac          <= '0;
            z_out       <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            if (issue_go) begin
                alu_a       <= ac;
                alu_b       <= op_operand;
                alu_control <= op_code;
                alu_enable  <= 1'b1;
            end else if (en_drop) begin
                alu_enable  <= 1'b0;
            end
            if (issue_go || mark_illegal) begin
                illegal_q <= mark_illegal;
            end
            if (capture) begin
                ac <= alu_c;
                if (alu_control == OP_SUB) begin
                    z_out <= (alu_c == '0);
                end
            end
            done <= finish;
            err  <= finish && illegal_q;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU
// that drives noise on C_bus while enable is high.
module tb_alu_issue_ctrl;

    localparam int DW  = 32;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [3:0]    op_code = 4'd0;
    logic [DW-1:0] op_operand = '0;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_control;
    logic          alu_enable;
    logic [DW-1:0] alu_c;
    logic [DW-1:0] ac_out;
    logic          z_out;
    logic          done;
    logic          err;

    logic [DW-1:0] noise = '0;
    int            n_checks = 0;
    int            n_fail = 0;
    logic [DW-1:0] model_ac = '0;
    logic          model_z = 1'b0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(
        .DATA_W  (DW),
        .LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_code     (op_code),
        .op_operand  (op_operand),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_enable  (alu_enable),
        .alu_c       (alu_c),
        .ac_out      (ac_out),
        .z_out       (z_out),
        .done        (done),
        .err         (err)
    );

    function automatic logic [DW-1:0] alu_model(input logic [3:0] op,
                                                input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        case (op)
            4'd1: return a + b;
            4'd2: return a - b;
            4'd3: return a * b;
            4'd4: return (b == '0) ? '0 : a % b;
            4'd5: return a;
            4'd6: return b;
            4'd7: return a + 1;
            4'd8: return a - 1;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk) noise <= $urandom;
    assign alu_c = alu_enable ? noise : alu_model(alu_control, alu_a, alu_b);

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act,
                        input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (op_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk1({tag, "_ready_wait"}, op_ready, 1'b1);
    endtask

    // Issue one op and check timing, ALU drive and the final AC/Z/err.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [DW-1:0] opnd,
                          input logic [DW-1:0] exp_ac,
                          input logic exp_z, input logic exp_err);
        int  done_at = 0;
        int  en_cnt = 0;
        bit  legal = (op >= 4'd1) && (op <= 4'd9);
        int  exp_done = legal ? LAT + 2 : 2;
        wait_ready(tag);
        op_valid   = 1'b1;
        op_code    = op;
        op_operand = opnd;
        @(negedge clk);
        op_valid   = 1'b0;
        op_code    = 4'($urandom);
        op_operand = $urandom;
        chk1({tag, "_busy"}, op_ready, 1'b0);
        for (int k = 1; k <= LAT + 4; k++) begin
            if (k > 1) @(negedge clk);
            if (alu_enable === 1'b1) begin
                en_cnt++;
                chk({tag, "_alu_a"}, alu_a, model_ac);
                chk({tag, "_alu_b"}, alu_b, opnd);
                chk4({tag, "_alu_ctl"}, alu_control, op);
            end
            if (done === 1'b1) begin
                done_at = k;
                break;
            end
        end
        chk({tag, "_done_cycle"}, 32'(done_at), 32'(exp_done));
        chk({tag, "_en_cycles"}, 32'(en_cnt), legal ? 32'(LAT) : 32'd0);
        chk1({tag, "_err"}, err, exp_err);
        chk({tag, "_ac"}, ac_out, exp_ac);
        chk1({tag, "_z"}, z_out, exp_z);
        @(negedge clk);
        chk1({tag, "_done_pulse"}, done, 1'b0);
        chk1({tag, "_ready_after"}, op_ready, 1'b1);
        model_ac = exp_ac;
        model_z  = exp_z;
    endtask

    typedef struct {
        logic [3:0]    op;
        logic [DW-1:0] opnd;
        logic [DW-1:0] ac;
        logic          z;
        logic          err;
    } vec_t;

    vec_t vecs[18];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{4'd1, 32'd5,          32'd5,          1'b0, 1'b0};
        vecs[1]  = '{4'd2, 32'd5,          32'd0,          1'b1, 1'b0};
        vecs[2]  = '{4'd1, 32'd7,          32'd7,          1'b1, 1'b0};
        vecs[3]  = '{4'hC, 32'd99,         32'd7,          1'b1, 1'b1};
        vecs[4]  = '{4'd7, 32'd0,          32'd8,          1'b1, 1'b0};
        vecs[5]  = '{4'd2, 32'd3,          32'd5,          1'b0, 1'b0};
        vecs[6]  = '{4'd6, 32'd100,        32'd100,        1'b0, 1'b0};
        vecs[7]  = '{4'd3, 32'd3,          32'd300,        1'b0, 1'b0};
        vecs[8]  = '{4'd4, 32'd7,          32'd6,          1'b0, 1'b0};
        vecs[9]  = '{4'd8, 32'd0,          32'd5,          1'b0, 1'b0};
        vecs[10] = '{4'd2, 32'd5,          32'd0,          1'b1, 1'b0};
        vecs[11] = '{4'd8, 32'd0,          32'hFFFF_FFFF,  1'b1, 1'b0};
        vecs[12] = '{4'd7, 32'd0,          32'd0,          1'b1, 1'b0};
        vecs[13] = '{4'd0, 32'd1,          32'd0,          1'b1, 1'b1};
        vecs[14] = '{4'd6, 32'hDEAD_BEEF,  32'hDEAD_BEEF,  1'b1, 1'b0};
        vecs[15] = '{4'd2, 32'hDEAD_BEEE,  32'd1,          1'b0, 1'b0};
        vecs[16] = '{4'd9, 32'd42,         32'd0,          1'b0, 1'b0};
        vecs[17] = '{4'hF, 32'd3,          32'd0,          1'b0, 1'b1};

        repeat (2) @(negedge clk);
        chk1("rst_ready", op_ready, 1'b0);
        chk1("rst_en", alu_enable, 1'b0);
        chk4("rst_ctl", alu_control, 4'd0);
        chk("rst_a", alu_a, '0);
        chk("rst_b", alu_b, '0);
        chk("rst_ac", ac_out, '0);
        chk1("rst_z", z_out, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk1("idle_ready", op_ready, 1'b1);

        for (int i = 0; i < 18; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].opnd,
                   vecs[i].ac, vecs[i].z, vecs[i].err);
        end

        // op_valid held through ISSUE: second op waits for IDLE
        begin
            logic [DW-1:0] x = 32'h10;
            logic [DW-1:0] y = 32'h20;
            int n = 0;
            wait_ready("hold");
            op_valid   = 1'b1;
            op_code    = 4'd1;
            op_operand = x;
            @(negedge clk);
            op_operand = y;
            for (int k = 1; k <= LAT + 2; k++) begin
                if (k > 1) @(negedge clk);
                chk1("hold_busy", op_ready, 1'b0);
                if (k <= LAT + 1) chk("hold_alu_b", alu_b, x);
            end
            chk1("hold_done1", done, 1'b1);
            @(negedge clk);
            chk1("hold_idle_ready", op_ready, 1'b1);
            chk1("hold_en_low", alu_enable, 1'b0);
            @(negedge clk);
            op_valid = 1'b0;
            chk1("hold_second_en", alu_enable, 1'b1);
            chk("hold_second_b", alu_b, y);
            chk("hold_second_a", alu_a, model_ac + x);
            while (done !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk1("hold_done2", done, 1'b1);
            chk("hold_ac", ac_out, model_ac + x + y);
            model_ac = model_ac + x + y;
            @(negedge clk);
        end

        // reset in the second ISSUE cycle aborts without a done pulse
        begin
            int seen = 0;
            wait_ready("rst_mid");
            op_valid   = 1'b1;
            op_code    = 4'd1;
            op_operand = 32'd9;
            @(negedge clk);
            op_valid = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
            @(negedge clk);
            chk1("rst_mid_en", alu_enable, 1'b0);
            chk("rst_mid_ac", ac_out, '0);
            chk1("rst_mid_ready", op_ready, 1'b1);
            chk1("rst_mid_z", z_out, 1'b0);
            if (done === 1'b1) seen++;
            repeat (8) begin
                @(negedge clk);
                if (done === 1'b1) seen++;
            end
            chk("rst_mid_no_done", 32'(seen), 32'd0);
            model_ac = '0;
            model_z  = 1'b0;
        end

        run_op("inc0", 4'd7, $urandom, 32'd1, 1'b0, 1'b0);
        run_op("inc1", 4'd7, $urandom, 32'd2, 1'b0, 1'b0);
        run_op("inc2", 4'd7, $urandom, 32'd3, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0]    op = 4'($urandom_range(0, 15));
            logic [DW-1:0] opnd = $urandom;
            logic [DW-1:0] exp_ac = model_ac;
            logic          exp_z = model_z;
            bit            legal;
            if (op == 4'd2 && $urandom_range(0, 2) == 0) opnd = model_ac;
            if (op == 4'd4) opnd = 32'($urandom_range(0, 50));
            legal = (op >= 4'd1) && (op <= 4'd9);
            if (legal) exp_ac = alu_model(op, model_ac, opnd);
            if (op == 4'd2) exp_z = (exp_ac == '0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op($sformatf("rnd%0d", i), op, opnd, exp_ac, exp_z, !legal);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
